addsub_arbiter: RTL



---
 rtl/addsub_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Two-port round-robin front end for one shared combinational add/sub unit.
// Requests are accepted in IDLE, run through the unit for one cycle, and the result is held until the owner takes it.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no operation in flight; grant one requester if any is valid
//   EXEC  | registered operands drive the shared unit; capture at the edge
//   RESP  | result and flags held for the owner until it accepts them
module addsub_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_carry,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,

    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               op_sub_q, op_sub_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;

    logic               grant_vld;
    logic               grant_id;
    logic               rsp_hs;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    always_comb begin
        rsp_hs = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sub_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sub_q     <= op_sub_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_vld) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand registers double as the shared-unit drivers, so they hold between operations.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sub_d     = op_sub_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (state_q == ST_IDLE && grant_vld) begin
            owner_d  = grant_id;
            op_a_d   = grant_id ? req1_a   : req0_a;
            op_b_d   = grant_id ? req1_b   : req0_b;
            op_sub_d = grant_id ? req1_sub : req0_sub;
        end
        if (state_q == ST_EXEC) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_carry, alu_zero, alu_overflow};
            last_grant_d = owner_q;
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        req0_ready = rst_n && (state_q == ST_IDLE) && grant_vld && !grant_id;
        req1_ready = rst_n && (state_q == ST_IDLE) && grant_vld &&  grant_id;
        rsp0_valid = (state_q == ST_RESP) && !owner_q;
        rsp1_valid = (state_q == ST_RESP) &&  owner_q;
        busy       = (state_q != ST_IDLE);
        alu_a      = op_a_q;
        alu_b      = op_b_q;
        alu_sub    = op_sub_q;
        rsp_result = rsp_result_q;
        rsp_flags  = rsp_flags_q;
    end

endmodule
